// File: rtl/ram_checker_if.sv
// Bus between the checker and a synchronous single-port RAM.
// The checker is the master. The RAM returns read data one cycle after it sees the address.
interface ram_checker_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (output ram_en, ram_we, ram_addr, ram_din, input ram_dout);
    modport slave  (input ram_en, ram_we, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/ram_checker.sv
// RAM march checker: writes a pattern to every address, then reads everything back and compares.
// It counts mismatches (saturating) and captures the address and read data of the first one.
module ram_checker #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pat,
    ram_checker_if.master     ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_vld;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] pat_q;
    logic              launch;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] p,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W+ADDR_W-1:0] ext;
        logic [DATA_W-1:0]        res;
        ext = {{DATA_W{1'b0}}, a};
        case (m)
            2'd0:    res = p;
            2'd1:    res = ext[DATA_W-1:0];
            2'd2:    res = DATA_W'(1) << (32'(a) % DATA_W);
            default: res = ~ext[DATA_W-1:0];
        endcase
        return res;
    endfunction

    assign launch   = start && !abort && (state == IDLE || state == DONE);
    assign mismatch = cmp_vld && (ram.ram_dout != pattern(mode_q, pat_q, cmp_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ram.ram_en   = 1'b0;
        ram.ram_we   = 1'b0;
        ram.ram_addr = '0;
        ram.ram_din  = '0;
        busy         = 1'b0;
        done         = 1'b0;
        pass         = 1'b0;
        case (state)
            WRITE: begin
                ram.ram_en   = 1'b1;
                ram.ram_we   = 1'b1;
                ram.ram_addr = cnt;
                ram.ram_din  = pattern(mode_q, pat_q, cnt);
                busy         = 1'b1;
                if (cnt == LAST) state_nxt = READ;
            end
            READ: begin
                ram.ram_en   = 1'b1;
                ram.ram_addr = cnt;
                busy         = 1'b1;
                if (cnt == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_cnt == '0);
            end
            default: ;
        endcase
        // Abort has the final say, so it beats a start in the same cycle.
        if (launch) state_nxt = WRITE;
        if (abort)  state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cmp_addr  <= '0;
            cmp_vld   <= 1'b0;
            mode_q    <= '0;
            pat_q     <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            // Each read is compared on the cycle after it is issued, once the RAM data is back.
            cmp_vld  <= (state == READ) && !abort;
            cmp_addr <= cnt;
            if (state == WRITE || state == READ) cnt <= cnt + 1'b1;
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) begin
                    fail_addr <= cmp_addr;
                    fail_data <= ram.ram_dout;
                end
            end
            if (abort) cnt <= '0;
            if (launch) begin
                mode_q    <= mode;
                pat_q     <= pat;
                cnt       <= '0;
                err_cnt   <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_checker.sv
// Directed bench for ram_checker with a 16-entry RAM model.
// A second instance (2-bit error counter, read bus stuck at 0) exercises saturation.
module tb_ram_checker;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] pat = '0;

    logic          busy, done, pass;
    logic [7:0]    err_cnt;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          busy2, done2, pass2;
    logic [1:0]    err2;
    logic [AW-1:0] fa2;
    logic [DW-1:0] fd2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_checker_if #(.DATA_W(DW), .ADDR_W(AW)) ram ();
    ram_checker_if #(.DATA_W(DW), .ADDR_W(AW)) ram2 ();

    ram_checker #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .pat(pat),
        .ram(ram), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    ram_checker #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .pat(pat),
        .ram(ram2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_addr(fa2), .fail_data(fd2)
    );

    // RAM model: synchronous single port, optional stuck-low bit 0 at address 3.
    logic [DW-1:0] mem [16];
    logic          fault3 = 1'b0;
    always @(posedge clk) begin
        if (ram.ram_en) begin
            if (ram.ram_we) mem[ram.ram_addr] <= ram.ram_din;
            else ram.ram_dout <= (fault3 && ram.ram_addr == 4'd3) ? (mem[ram.ram_addr] & 8'hFE)
                                                                  : mem[ram.ram_addr];
        end
    end
    assign ram2.ram_dout = '0;

    int            wcount = 0;
    logic [DW-1:0] din9 = '0;
    always @(negedge clk) begin
        if (ram.ram_en && ram.ram_we) begin
            wcount <= wcount + 1;
            if (ram.ram_addr == 4'd9) din9 <= ram.ram_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    int base;

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_en", 32'(ram.ram_en), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Mode 1 (address pattern) on a healthy RAM.
        mode = 2'd1;
        base = wcount;
        pulse_start();
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_we", 32'(ram.ram_we), 32'd1);
        chk("c1_addr", 32'(ram.ram_addr), 32'd0);
        chk("c1_din", 32'(ram.ram_din), 32'd0);
        repeat (32) @(posedge clk);
        #1;
        chk("c33_done", 32'(done), 32'd0);
        chk("c33_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("c34_done", 32'(done), 32'd1);
        chk("c34_pass", 32'(pass), 32'd1);
        chk("c34_err", 32'(err_cnt), 32'd0);
        chk("c34_busy", 32'(busy), 32'd0);
        chk("c34_en", 32'(ram.ram_en), 32'd0);
        chk("m1_writes", 32'(wcount - base), 32'd16);
        chk("m1_mem15", 32'(mem[15]), 32'h0F);

        // Mode 0 (constant A5) with bit 0 stuck low at address 3.
        mode = 2'd0;
        pat = 8'hA5;
        fault3 = 1'b1;
        pulse_start();
        wait_done("m0");
        chk("m0_err", 32'(err_cnt), 32'd1);
        chk("m0_faddr", 32'(fail_addr), 32'd3);
        chk("m0_fdata", 32'(fail_data), 32'hA4);
        chk("m0_pass", 32'(pass), 32'd0);
        fault3 = 1'b0;
        // Abort from DONE drops the status flags but keeps the error record.
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_pass", 32'(pass), 32'd0);
        chk("ab_err", 32'(err_cnt), 32'd1);
        chk("ab_faddr", 32'(fail_addr), 32'd3);

        // Mode 2 (walking one); the second instance sees a read bus stuck at 0.
        mode = 2'd2;
        pulse_start();
        wait_done("m2");
        chk("m2_pass", 32'(pass), 32'd1);
        chk("m2_din9", 32'(din9), 32'h02);
        chk("sat_done", 32'(done2), 32'd1);
        chk("sat_busy", 32'(busy2), 32'd0);
        chk("sat_err", 32'(err2), 32'd3);
        chk("sat_faddr", 32'(fa2), 32'd0);
        chk("sat_fdata", 32'(fd2), 32'h00);
        chk("sat_pass", 32'(pass2), 32'd0);

        // Mode 3 (inverted address).
        mode = 2'd3;
        pulse_start();
        wait_done("m3");
        chk("m3_din9", 32'(din9), 32'hF6);
        chk("m3_pass", 32'(pass), 32'd1);

        // A second start during the run is ignored; abort then returns the checker to IDLE.
        mode = 2'd1;
        pulse_start();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("rs_addr", 32'(ram.ram_addr), 32'd3);
        chk("rs_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("c6_busy", 32'(busy), 32'd0);
        chk("c6_we", 32'(ram.ram_we), 32'd0);
        chk("c6_en", 32'(ram.ram_en), 32'd0);
        chk("c6_done", 32'(done), 32'd0);

        // Start and abort in the same cycle resolve to abort.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_we", 32'(ram.ram_we), 32'd0);

        // Asynchronous reset in the middle of READ.
        pulse_start();
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst_read", 32'(ram.ram_en & ~ram.ram_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_en", 32'(ram.ram_en), 32'd0);
        chk("ar_addr", 32'(ram.ram_addr), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;
        base = wcount;
        @(posedge clk);
        #1;
        chk("post_rst_we", 32'(ram.ram_we), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_writes", 32'(wcount - base), 32'd0);
        pulse_start();
        wait_done("rerun");
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_err", 32'(err_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
